// File: rtl/mem_pkg.sv
// Shared types for the memory-stage access unit: funct3 codes, FSM states,
// the latched command record and the byte-strobe helper.
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_e;

    typedef struct packed {
        logic [2:0]  funct3;
        logic [1:0]  lane;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } mem_cmd_t;

    // size is funct3[1:0]; half accesses only look at lo[1]
    function automatic logic [3:0] size_strb(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   return 4'b0001 << lo;
            2'b01:   return 4'b0011 << {lo[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load-data alignment: picks the byte/half at the latched lane
// and sign- or zero-extends it according to funct3.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data = {24'h0, byte_sel};
            F3_LHU:  data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller (IDLE/REQ/WAIT/DONE).
// Define MEM_MISALIGN_CHECK_EN to trap misaligned half/word accesses via misalign_exc.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [2:0]        mem_funct3,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              hold_in,
    output logic              dm_req_valid,
    input  logic              dm_req_ready,
    output logic [ADDR_W-1:0] dm_req_addr,
    output logic              dm_req_we,
    output logic [3:0]        dm_req_wstrb,
    output logic [DATA_W-1:0] dm_req_wdata,
    input  logic              dm_rsp_valid,
    input  logic [DATA_W-1:0] dm_rsp_rdata,
    output logic              mem_stall,
    output logic [DATA_W-1:0] DM_data,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic              misalign_exc,
`endif
    output mem_state_e        dbg_state
);

    // Handshake: a request is offered while dm_req_valid=1 and transfers on the
    // first rising edge with dm_req_ready=1; fields stay frozen until then. The
    // response is accepted on a dm_rsp_valid edge only while in WAIT.

    mem_state_e        state;
    mem_cmd_t          cmd;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] wdata_rep;
    logic              access;
    logic              misaligned;

    assign access = mem_rd | mem_wr;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misaligned = ((mem_funct3[1:0] == 2'b01) && mem_addr[0]) ||
                        ((mem_funct3[1:0] == 2'b10) && (mem_addr[1:0] != 2'b00));
    assign misalign_exc = (state == IDLE) && access && misaligned;
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        case (mem_funct3[1:0])
            2'b00:   wdata_rep = {4{mem_wdata[7:0]}};
            2'b01:   wdata_rep = {2{mem_wdata[15:0]}};
            default: wdata_rep = mem_wdata;
        endcase
    end

    load_align u_load_align (
        .rdata  (dm_rsp_rdata),
        .lane   (cmd.lane),
        .funct3 (cmd.funct3),
        .data   (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cmd     <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (access && !misaligned) begin
                    addr_q     <= {mem_addr[ADDR_W-1:2], 2'b00};
                    cmd.lane   <= mem_addr[1:0];
                    cmd.funct3 <= mem_funct3;
                    cmd.we     <= mem_wr;
                    cmd.wstrb  <= size_strb(mem_funct3[1:0], mem_addr[1:0]);
                    cmd.wdata  <= wdata_rep;
                    state      <= REQ;
                end
                REQ: if (dm_req_ready) state <= WAIT;
                WAIT: if (dm_rsp_valid) begin
                    // store acknowledges carry no useful data
                    rdata_q <= cmd.we ? '0 : load_data;
                    state   <= DONE;
                end
                DONE: if (!hold_in) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign dm_req_valid = (state == REQ);
    assign dm_req_addr  = addr_q;
    assign dm_req_we    = cmd.we;
    assign dm_req_wstrb = cmd.wstrb;
    assign dm_req_wdata = cmd.wdata;
    assign mem_stall    = ((state == IDLE) && access && !misaligned) ||
                          (state == REQ) || (state == WAIT);
    assign DM_data      = (state == DONE) ? rdata_q : '0;
    assign dbg_state    = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, ready back-pressure,
// DONE hold, mid-transaction reset and (with MEM_MISALIGN_CHECK_EN) misalign traps.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [2:0]  mem_funct3 = '0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        hold_in = 1'b0;
    logic        dm_req_valid;
    logic        dm_req_ready = 1'b0;
    logic [31:0] dm_req_addr;
    logic        dm_req_we;
    logic [3:0]  dm_req_wstrb;
    logic [31:0] dm_req_wdata;
    logic        dm_rsp_valid = 1'b0;
    logic [31:0] dm_rsp_rdata = '0;
    logic        mem_stall;
    logic [31:0] DM_data;
    mem_state_e  dbg_state;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        misalign_exc;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_funct3   (mem_funct3),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .hold_in      (hold_in),
        .dm_req_valid (dm_req_valid),
        .dm_req_ready (dm_req_ready),
        .dm_req_addr  (dm_req_addr),
        .dm_req_we    (dm_req_we),
        .dm_req_wstrb (dm_req_wstrb),
        .dm_req_wdata (dm_req_wdata),
        .dm_rsp_valid (dm_rsp_valid),
        .dm_rsp_rdata (dm_rsp_rdata),
        .mem_stall    (mem_stall),
        .DM_data      (DM_data),
`ifdef MEM_MISALIGN_CHECK_EN
        .misalign_exc (misalign_exc),
`endif
        .dbg_state    (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One access, with the bench acting as the memory: ready after rdy_dly
    // cycles of valid, response the cycle after the handshake.
    task automatic do_access(input string tag, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int rdy_dly, input int hold_cyc,
                             input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                             input logic [31:0] exp_wdata, input logic [31:0] exp_data,
                             input int exp_stall);
        int  stalls = 0;
        int  waited = 0;
        int  holds = 0;
        int  phase = 0;
        bit  fin = 1'b0;
        bit  hs;
        @(negedge clk);
        mem_rd = !wr; mem_wr = wr; mem_funct3 = f3; mem_addr = addr; mem_wdata = wdata;
        hold_in = 1'b0;
        for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            if (mem_stall) stalls++;
            hs = 1'b0;
            case (phase)
                0: begin
                    dm_rsp_valid = 1'b0;
                    if (dm_req_valid) begin
                        check({tag, " req_addr"}, dm_req_addr, exp_addr);
                        check({tag, " req_we"}, 32'(dm_req_we), 32'(wr));
                        check({tag, " req_wstrb"}, 32'(dm_req_wstrb), 32'(exp_strb));
                        check({tag, " req_wdata"}, dm_req_wdata, exp_wdata);
                        dm_req_ready = (waited >= rdy_dly);
                        if (!dm_req_ready) waited++;
                        hs = dm_req_ready;
                    end else begin
                        dm_req_ready = 1'b0;
                    end
                end
                1: begin
                    dm_req_ready = 1'b0;
                    dm_rsp_valid = 1'b1;
                    dm_rsp_rdata = rdata;
                end
                default: begin
                    dm_rsp_valid = 1'b0;
                    dm_rsp_rdata = 32'hA5A5_A5A5;
                    check({tag, " state_done"}, 32'(dbg_state), 32'(DONE));
                    check({tag, " dm_data"}, DM_data, exp_data);
                    if (holds < hold_cyc) begin
                        hold_in = 1'b1;
                        holds++;
                    end else begin
                        hold_in = 1'b0;
                        fin = 1'b1;
                    end
                end
            endcase
            @(posedge clk);
            if (phase == 0 && hs) phase = 1;
            else if (phase == 1) phase = 2;
        end
        #1;
        mem_rd = 1'b0; mem_wr = 1'b0; hold_in = 1'b0;
        dm_rsp_valid = 1'b0; dm_req_ready = 1'b0;
        if (!fin) check({tag, " timeout"}, 32'd0, 32'd1);
        check({tag, " stall_cycles"}, 32'(stalls), 32'(exp_stall));
        check({tag, " back_to_idle"}, 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst valid", 32'(dm_req_valid), 32'd0);
        check("rst we", 32'(dm_req_we), 32'd0);
        check("rst stall", 32'(mem_stall), 32'd0);
        check("rst addr", dm_req_addr, 32'd0);
        check("rst wstrb", 32'(dm_req_wstrb), 32'd0);
        check("rst wdata", dm_req_wdata, 32'd0);
        check("rst dm_data", DM_data, 32'd0);
        check("rst state", 32'(dbg_state), 32'(IDLE));
`ifdef MEM_MISALIGN_CHECK_EN
        check("rst misalign", 32'(misalign_exc), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        //        tag    wr    f3      addr          wdata         rdata         rdy hold exp_addr      strb     exp_wdata     exp_data      stall
        do_access("LW",  1'b0, F3_LW,  32'h0000_0100, 32'h0,       32'hDEAD_BEEF, 0, 0, 32'h0000_0100, 4'b1111, 32'h0,        32'hDEAD_BEEF, 3);
        do_access("LB",  1'b0, F3_LB,  32'h0000_0203, 32'h0,       32'h80FF_FF7F, 0, 0, 32'h0000_0200, 4'b1000, 32'h0,        32'hFFFF_FF80, 3);
        do_access("LBU", 1'b0, F3_LBU, 32'h0000_0203, 32'h0,       32'h80FF_FF7F, 0, 0, 32'h0000_0200, 4'b1000, 32'h0,        32'h0000_0080, 3);
        do_access("SH",  1'b1, F3_LH,  32'h0000_0302, 32'h1234,    32'hFFFF_FFFF, 0, 0, 32'h0000_0300, 4'b1100, 32'h1234_1234, 32'h0,        3);
        do_access("LH",  1'b0, F3_LH,  32'h0000_0102, 32'h0,       32'h8001_1234, 4, 2, 32'h0000_0100, 4'b1100, 32'h0,        32'hFFFF_8001, 7);
        do_access("LHU", 1'b0, F3_LHU, 32'h0000_0000, 32'h0,       32'h1234_F00D, 0, 0, 32'h0000_0000, 4'b0011, 32'h0,        32'h0000_F00D, 3);
        do_access("SB",  1'b1, F3_LB,  32'h0000_0001, 32'h0000_00AB, 32'h0,      1, 0, 32'h0000_0000, 4'b0010, 32'hABAB_ABAB, 32'h0,        4);
        do_access("SW",  1'b1, F3_LW,  32'h0000_0044, 32'hCAFE_F00D, 32'h0,      0, 1, 32'h0000_0044, 4'b1111, 32'hCAFE_F00D, 32'h0,        3);

        // reset asserted while waiting for the response
        @(negedge clk);
        mem_rd = 1'b1; mem_funct3 = F3_LW; mem_addr = 32'h0000_0400; dm_req_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        dm_req_ready = 1'b0;
        check("rstmid in_wait", 32'(dbg_state), 32'(WAIT));
        @(negedge clk);
        rst_n = 1'b0; mem_rd = 1'b0;
        #1;
        check("rstmid state", 32'(dbg_state), 32'(IDLE));
        check("rstmid valid", 32'(dm_req_valid), 32'd0);
        check("rstmid stall", 32'(mem_stall), 32'd0);
        check("rstmid addr", dm_req_addr, 32'd0);
        check("rstmid dm_data", DM_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; dm_rsp_valid = 1'b1; dm_rsp_rdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        dm_rsp_valid = 1'b0;
        check("stray_rsp state", 32'(dbg_state), 32'(IDLE));
        check("stray_rsp dm_data", DM_data, 32'd0);
        check("stray_rsp valid", 32'(dm_req_valid), 32'd0);

`ifdef MEM_MISALIGN_CHECK_EN
        @(negedge clk);
        mem_rd = 1'b1; mem_funct3 = F3_LW; mem_addr = 32'h0000_0102;
        #1;
        check("mis_lw exc", 32'(misalign_exc), 32'd1);
        check("mis_lw stall", 32'(mem_stall), 32'd0);
        check("mis_lw valid", 32'(dm_req_valid), 32'd0);
        @(posedge clk);
        #1;
        mem_rd = 1'b0;
        #1;
        check("mis_lw exc_off", 32'(misalign_exc), 32'd0);
        check("mis_lw no_req", 32'(dm_req_valid), 32'd0);
        check("mis_lw state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        mem_wr = 1'b1; mem_funct3 = F3_LH; mem_addr = 32'h0000_0101;
        #1;
        check("mis_sh exc", 32'(misalign_exc), 32'd1);
        check("mis_sh stall", 32'(mem_stall), 32'd0);
        @(posedge clk);
        #1;
        mem_wr = 1'b0;
        check("mis_sh state", 32'(dbg_state), 32'(IDLE));
`else
        // without checking, the unusable low address bits are dropped
        do_access("LWU", 1'b0, F3_LW, 32'h0000_0102, 32'h0, 32'h0BAD_CAFE, 0, 0, 32'h0000_0100, 4'b1111, 32'h0, 32'h0BAD_CAFE, 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
